dice_roller: RTL and testbench
==============================

Name: dice_roller

Overview:
Electronic dice stage that produces the 3-bit face value driven into the "a" input of the downstream 3-bit 2:1 selector. While the button is held, the face cycles rapidly through 1..6. On release it decelerates over a fixed number of lengthening steps, then holds the final face and pulses done. The output face is registered and is always in the range 1..6 during normal operation.

Parameters:
BASE_DIV, 1, clock cycles per face advance while rolling; also the unit of the slow-down dwell; must be >=1
SLOW_STEPS, 4, number of face advances performed after button release; must be >=1

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous reset, active-high
button  input  1  roll request; assumed already synchronised and debounced upstream
throw  output  3  current face value, 3'd1..3'd6; feeds the selector "a" input
rolling  output  1  high while in ROLL or SLOW
done  output  1  single-cycle pulse when a throw settles

Behaviour:
- Interface: one clock, clk; rst is synchronous and active-high.
- All outputs are registered.
- Reset (rst=1 at a rising edge):
  - state=IDLE, throw=3'd1, rolling=0, done=0
  - divider and step counters cleared
  - rst overrides every other input, including mid-ROLL or mid-SLOW.
- Face advance: 1->2->3->4->5->6->1. If throw ever holds 0 or 7, the next advance yields 1.
- States:
  - IDLE (after reset):
    - button=1 -> ROLL; divider cleared; no advance on that cycle.
  - ROLL:
    - Each cycle with button=1, divider increments.
    - When divider==BASE_DIV-1: throw advances and divider returns to 0.
    - With BASE_DIV=1, throw advances on every ROLL cycle.
    - button=0 -> SLOW; no advance on that cycle; divider=0, step k=0.
  - SLOW:
    - divider increments every cycle.
    - When divider==(k+2)*BASE_DIV-1: throw advances, divider=0, k increments.
    - Dwell of step k is therefore (k+2)*BASE_DIV cycles.
    - On the advance with k==SLOW_STEPS-1 -> HOLD. done=1 in the same registered cycle that presents the final throw.
    - button is ignored in SLOW; the throw always completes.
  - HOLD:
    - throw is stable; done=0 from the second HOLD cycle onward.
    - button=1 -> ROLL, same as from IDLE.
- rolling=1 exactly when the state is ROLL or SLOW.
- done is never high for more than one consecutive cycle and never high outside the HOLD entry cycle.
- Total SLOW duration is BASE_DIV*(sum over k=0..SLOW_STEPS-1 of (k+2)) cycles. For the defaults this is 14 cycles.
- Counter width is sized for the largest dwell, (SLOW_STEPS+1)*BASE_DIV; there is no overflow at legal parameters.
- Button pulse of a single cycle in IDLE/HOLD:
  - enters ROLL, sees button=0 on the next cycle, goes to SLOW;
  - yields zero ROLL advances and exactly SLOW_STEPS SLOW advances.

Test Plan:
- Reset: hold rst 2 cycles with button=1 -> throw=1, rolling=0, done=0; state stays IDLE while rst=1.
- Defaults, roll and settle:
  - button=1 one cycle in IDLE, then held for 8 ROLL cycles -> throw sequence 2,3,4,5,6,1,2,3, rolling=1.
  - Release -> throw stays 3 for 2 cycles, then 4; 3 cycles later 5; 4 cycles later 6; 5 cycles later 1.
  - done=1 on exactly that cycle, rolling=0 from then on; throw holds 1.
- Button during SLOW: repeat the previous run, toggling button high/low during SLOW -> identical face sequence and timing; done pulses once.
- Reset mid-SLOW: assert rst on the 5th SLOW cycle -> next cycle throw=1, rolling=0, done=0, IDLE; a new button press restarts cleanly.
- BASE_DIV=3, SLOW_STEPS=2:
  - 9 ROLL cycles with button=1 -> 3 advances, throw=4.
  - Release -> advances after 6 and then 9 cycles, throw=6, then done pulse.
- Re-roll from HOLD:
  - After done, button=1 -> ROLL next cycle, rolling=1.
  - A one-cycle button pulse gives exactly SLOW_STEPS advances and a single done.

Source files
------------

// File: rtl/dice_if.sv
// Handshake bundle between the dice roller and its consumer: roll request in,
// registered face value and status out.
interface dice_if;
   logic       button;
   logic [2:0] throw;
   logic       rolling;
   logic       done;

   modport master (output button, input throw, rolling, done);
   modport slave  (input button, output throw, rolling, done);
endinterface

// File: rtl/dice_roller.sv
// Electronic dice: fast face cycling while the button is held, then a fixed
// number of progressively slower advances before settling on a final face.
module dice_roller #(
   parameter int BASE_DIV   = 1,
   parameter int SLOW_STEPS = 4
) (
   input  logic clk,
   input  logic rst,
   dice_if.slave bus
);
   localparam int DW = $clog2((SLOW_STEPS + 1) * BASE_DIV + 1);
   localparam int KW = $clog2(SLOW_STEPS + 1);
   localparam logic [DW-1:0] ROLL_LAST = DW'(BASE_DIV - 1);
   localparam logic [KW-1:0] K_LAST    = KW'(SLOW_STEPS - 1);

   typedef enum logic [1:0] {IDLE, ROLL, SLOW, HOLD} state_t;

   state_t        state;
   logic [DW-1:0] div;
   logic [KW-1:0] k;
   logic [2:0]    throw;
   logic          rolling;
   logic          done;
   logic [DW-1:0] slow_last;

   // Dwell of slow-down step k is (k+2)*BASE_DIV cycles.
   assign slow_last = DW'((int'(k) + 2) * BASE_DIV - 1);

   function automatic logic [2:0] next_face(input logic [2:0] f);
      if (f == 3'd0 || f >= 3'd6) return 3'd1;
      return f + 3'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         div     <= '0;
         k       <= '0;
         throw   <= 3'd1;
         rolling <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, HOLD: begin
               if (bus.button) begin
                  state   <= ROLL;
                  div     <= '0;
                  rolling <= 1'b1;
               end
            end
            ROLL: begin
               if (!bus.button) begin
                  state <= SLOW;
                  div   <= '0;
                  k     <= '0;
               end else if (div == ROLL_LAST) begin
                  throw <= next_face(throw);
                  div   <= '0;
               end else begin
                  div <= div + 1'b1;
               end
            end
            SLOW: begin
               // button is deliberately ignored so a started throw always completes
               if (div == slow_last) begin
                  throw <= next_face(throw);
                  div   <= '0;
                  k     <= k + 1'b1;
                  if (k == K_LAST) begin
                     state   <= HOLD;
                     rolling <= 1'b0;
                     done    <= 1'b1;
                  end
               end else begin
                  div <= div + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               rolling <= 1'b0;
            end
         endcase
      end
   end

   assign bus.throw   = throw;
   assign bus.rolling = rolling;
   assign bus.done    = done;
endmodule

// File: tb/tb_dice_roller.sv
// Directed bench: default-parameter roller plus a BASE_DIV=3/SLOW_STEPS=2 roller.
module tb_dice_roller;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   dice_if d ();
   dice_if s ();

   dice_roller #(.BASE_DIV(1), .SLOW_STEPS(4)) u_def (.clk(clk), .rst(rst), .bus(d.slave));
   dice_roller #(.BASE_DIV(3), .SLOW_STEPS(2)) u_slw (.clk(clk), .rst(rst), .bus(s.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      d.button = 1'b1;
      s.button = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (d.throw !== 3'd1 || d.rolling !== 1'b0 || d.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_def cyc%0d: throw=%0d rolling=%b done=%b, want 1/0/0", i, d.throw, d.rolling, d.done);
         end
         total++;
         if (s.throw !== 3'd1 || s.rolling !== 1'b0 || s.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_slw cyc%0d: throw=%0d rolling=%b done=%b, want 1/0/0", i, s.throw, s.rolling, s.done);
         end
      end
      rst = 1'b0;
      d.button = 1'b0;
      s.button = 1'b0;
      tick();
      total++;
      if (d.rolling !== 1'b0 || d.throw !== 3'd1) begin
         bad++;
         $display("FAIL reset_idle: rolling=%b throw=%0d, want 0/1", d.rolling, d.throw);
      end
   endtask

   // Starts from IDLE/HOLD with throw=1; optional button toggling during SLOW.
   task automatic test_roll_settle(input bit toggle);
      logic [2:0] roll_exp [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2, 3'd3};
      logic [2:0] slow_exp [14] = '{3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5,
                                    3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd1};
      d.button = 1'b1;
      tick();
      total++;
      if (d.rolling !== 1'b1 || d.throw !== 3'd1) begin
         bad++;
         $display("FAIL roll_enter t%0d: rolling=%b throw=%0d, want 1/1", toggle, d.rolling, d.throw);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if (d.throw !== roll_exp[i] || d.rolling !== 1'b1) begin
            bad++;
            $display("FAIL roll_seq t%0d c%0d: throw=%0d rolling=%b, want %0d/1", toggle, i, d.throw, d.rolling, roll_exp[i]);
         end
      end
      d.button = 1'b0;
      tick();
      total++;
      if (d.throw !== 3'd3 || d.rolling !== 1'b1 || d.done !== 1'b0) begin
         bad++;
         $display("FAIL release t%0d: throw=%0d rolling=%b done=%b, want 3/1/0", toggle, d.throw, d.rolling, d.done);
      end
      for (int c = 0; c < 14; c++) begin
         d.button = toggle && (c % 2 == 0) && (c < 13);
         tick();
         total++;
         if (d.throw !== slow_exp[c] || d.done !== (c == 13) || d.rolling !== (c != 13)) begin
            bad++;
            $display("FAIL slow_seq t%0d c%0d: throw=%0d done=%b rolling=%b, want %0d/%b/%b",
                     toggle, c, d.throw, d.done, d.rolling, slow_exp[c], c == 13, c != 13);
         end
      end
      d.button = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (d.throw !== 3'd1 || d.done !== 1'b0 || d.rolling !== 1'b0) begin
            bad++;
            $display("FAIL hold t%0d c%0d: throw=%0d done=%b rolling=%b, want 1/0/0", toggle, i, d.throw, d.done, d.rolling);
         end
      end
   endtask

   task automatic test_reset_mid_slow();
      d.button = 1'b1;
      tick();
      tick();
      tick();
      d.button = 1'b0;
      tick();
      total++;
      if (d.throw !== 3'd3 || d.rolling !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre: throw=%0d rolling=%b, want 3/1", d.throw, d.rolling);
      end
      for (int c = 0; c < 4; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (d.throw !== 3'd1 || d.rolling !== 1'b0 || d.done !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: throw=%0d rolling=%b done=%b, want 1/0/0", d.throw, d.rolling, d.done);
      end
      tick();
      total++;
      if (d.rolling !== 1'b0 || d.done !== 1'b0) begin
         bad++;
         $display("FAIL mid_idle: rolling=%b done=%b, want 0/0", d.rolling, d.done);
      end
   endtask

   task automatic test_slow_params();
      logic [2:0] roll_exp [9] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
      logic [2:0] want;
      s.button = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) begin
         tick();
         total++;
         if (s.throw !== roll_exp[i] || s.rolling !== 1'b1) begin
            bad++;
            $display("FAIL p_roll c%0d: throw=%0d rolling=%b, want %0d/1", i, s.throw, s.rolling, roll_exp[i]);
         end
      end
      s.button = 1'b0;
      tick();
      for (int c = 1; c <= 15; c++) begin
         tick();
         want = (c < 6) ? 3'd4 : (c < 15) ? 3'd5 : 3'd6;
         total++;
         if (s.throw !== want || s.done !== (c == 15) || s.rolling !== (c != 15)) begin
            bad++;
            $display("FAIL p_slow c%0d: throw=%0d done=%b rolling=%b, want %0d/%b/%b",
                     c, s.throw, s.done, s.rolling, want, c == 15, c != 15);
         end
      end
      tick();
      total++;
      if (s.done !== 1'b0 || s.throw !== 3'd6) begin
         bad++;
         $display("FAIL p_hold: done=%b throw=%0d, want 0/6", s.done, s.throw);
      end
   endtask

   task automatic test_reroll_pulse();
      logic [2:0] slow_exp [14] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3,
                                    3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
      int dones = 0;
      d.button = 1'b1;
      tick();
      d.button = 1'b0;
      total++;
      if (d.rolling !== 1'b1 || d.throw !== 3'd1) begin
         bad++;
         $display("FAIL reroll_enter: rolling=%b throw=%0d, want 1/1", d.rolling, d.throw);
      end
      tick();
      for (int c = 0; c < 14; c++) begin
         tick();
         if (d.done === 1'b1) dones++;
         total++;
         if (d.throw !== slow_exp[c]) begin
            bad++;
            $display("FAIL pulse_seq c%0d: throw=%0d, want %0d", c, d.throw, slow_exp[c]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (d.done === 1'b1) dones++;
      end
      total++;
      if (dones != 1 || d.throw !== 3'd5 || d.rolling !== 1'b0) begin
         bad++;
         $display("FAIL pulse_done: dones=%0d throw=%0d rolling=%b, want 1/5/0", dones, d.throw, d.rolling);
      end
   endtask

   initial begin
      rst = 1'b1;
      d.button = 1'b0;
      s.button = 1'b0;
      test_reset();
      test_roll_settle(1'b0);
      test_roll_settle(1'b1);
      test_reset_mid_slow();
      test_roll_settle(1'b0);
      test_slow_params();
      test_reroll_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
